// File: rtl/md_unit_pkg.sv
// Shared op codes for the multiply/divide unit and the decode logic that drives it.
package md_unit_pkg;

  localparam logic [2:0] md_none  = 3'd0;
  localparam logic [2:0] md_mult  = 3'd1;
  localparam logic [2:0] md_multu = 3'd2;
  localparam logic [2:0] md_div   = 3'd3;
  localparam logic [2:0] md_divu  = 3'd4;
  localparam logic [2:0] md_mthi  = 3'd5;
  localparam logic [2:0] md_mtlo  = 3'd6;

  function automatic logic is_mult_op(logic [2:0] op);
    return (op == md_mult) || (op == md_multu);
  endfunction

  function automatic logic is_div_op(logic [2:0] op);
    return (op == md_div) || (op == md_divu);
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO and holds busy for a fixed number of cycles
// per mult/div so the hazard logic can stall dependent md ops and mfhi/mflo.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  mdctr,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        last, accept;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, uq, ur, quot, rem;
  logic [31:0] res_hi, res_lo;

  // Result arithmetic works on the captured operands; it only matters on the last RUN cycle.
  always_comb begin
    a_ext  = {{32{a_q[31] & (op_q == md_mult)}}, a_q};
    b_ext  = {{32{b_q[31] & (op_q == md_mult)}}, b_q};
    prod   = a_ext * b_ext;
    a_neg  = (op_q == md_div) && a_q[31];
    b_neg  = (op_q == md_div) && b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq     = a_mag / b_div;
    ur     = a_mag % b_div;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quot   = (a_neg ^ b_neg) ? -uq : uq;
    rem    = a_neg ? -ur : ur;
    res_hi = is_mult_op(op_q) ? prod[63:32] : rem;
    res_lo = is_mult_op(op_q) ? prod[31:0]  : quot;
  end

  // The final RUN cycle doubles as an accept slot so back-to-back ops do not lose a cycle.
  assign last   = (state_q == StRun) && (cnt_q == 32'd0);
  assign accept = start && ((state_q == StIdle) || last) &&
                  (mdctr != md_none) && (mdctr != 3'd7);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (state_q == StRun) begin
      if (cnt_q == 32'd0) begin
        state_d = StIdle;
        if (!(is_div_op(op_q) && (b_q == 32'd0))) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end

    if (accept) begin
      case (mdctr)
        md_mthi: hi_d = A;
        md_mtlo: lo_d = A;
        default: begin
          state_d = StRun;
          op_d    = mdctr;
          a_d     = A;
          b_d     = B;
          cnt_d   = is_mult_op(mdctr) ? 32'(MULT_CYCLES - 1) : 32'(DIV_CYCLES - 1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= md_none;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random ops against a
// 64-bit arithmetic model of HI/LO and the fixed busy duration per op class.
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  mdctr = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .A      (A),
    .B      (B),
    .mdctr  (mdctr),
    .start  (start),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op, straight from the instruction definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: begin p = 64'(a) * 64'(b); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd3: if (b != 0) begin
        sq = sa / sb; sr = sa % sb;
        lo_m = sq[31:0]; hi_m = sr[31:0];
      end
      3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  function automatic int busy_len(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MC;
    if (op == 3'd3 || op == 3'd4) return DC;
    return 0;
  endfunction

  // Counts negedges with busy high; HI/LO must hold their old values meanwhile.
  task automatic wait_idle(input string tag, input int exp_n);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      chk({tag, "_hold_hi"}, HI, hi_m);
      chk({tag, "_hold_lo"}, LO, lo_m);
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mdctr = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; mdctr = 3'd0; A = $urandom; B = $urandom;
    if (op == 3'd5 || op == 3'd6) model(op, a, b);
    wait_idle(tag, busy_len(op));
    if (op != 3'd5 && op != 3'd6) model(op, a, b);
    chk({tag, "_hi"}, HI, hi_m);
    chk({tag, "_lo"}, LO, lo_m);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;

    // Reset, with a start held during the first edge that must be ignored.
    start = 1'b1; mdctr = 3'd5; A = 32'h55;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(negedge clk);
    start = 1'b0; mdctr = 3'd0;
    reset_n = 1'b1;
    chk("rst_start_ignored", HI, 32'd0);

    // Reset mid-op discards the mult.
    @(negedge clk);
    start = 1'b1; mdctr = 3'd1; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0; mdctr = 3'd0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_later_busy", {31'b0, busy}, 32'd0);
    chk("midrst_later_lo", LO, 32'd0);

    // Directed cases with literal expectations.
    run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi_lit", HI, 32'hFFFF_FFFF);
    chk("mult_lo_lit", LO, 32'hFFFF_FFFE);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_lit", HI, 32'h0000_0001);
    chk("multu_lo_lit", LO, 32'hFFFF_FFFE);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_lit", LO, 32'hFFFF_FFFD);
    chk("div_hi_lit", HI, 32'hFFFF_FFFF);
    run_op("mthi", 3'd5, 32'h11, 32'd0);
    run_op("mtlo", 3'd6, 32'h22, 32'd0);
    run_op("divu0", 3'd4, 32'd7, 32'd0);
    chk("divu0_hi_lit", HI, 32'h11);
    chk("divu0_lo_lit", LO, 32'h22);
    run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divovf_lo_lit", LO, 32'h8000_0000);
    chk("divovf_hi_lit", HI, 32'h0);
    run_op("none", 3'd0, 32'hABCD, 32'd1);
    run_op("rsvd", 3'd7, 32'hABCD, 32'd1);

    // mthi, then a mult with an mtlo issued while busy: the mtlo is dropped.
    run_op("mthi2", 3'd5, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk);
    start = 1'b1; mdctr = 3'd1; A = 32'd6; B = 32'hFFFF_FFF9;
    @(negedge clk);
    start = 1'b1; mdctr = 3'd6; A = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; mdctr = 3'd0;
    chk("mtlo_busy_hi", HI, 32'hDEAD_BEEF);
    wait_idle("mtlo_busy", MC - 1);
    model(3'd1, 32'd6, 32'hFFFF_FFF9);
    chk("mtlo_busy_res_hi", HI, hi_m);
    chk("mtlo_busy_res_lo", LO, lo_m);
    chk("mtlo_busy_res_lit", LO, 32'hFFFF_FFD6);

    // Back-to-back: second mult issued on the first one's last busy cycle.
    @(negedge clk);
    start = 1'b1; mdctr = 3'd1; A = 32'd7; B = 32'd9;
    @(negedge clk);
    start = 1'b0; mdctr = 3'd0;
    repeat (MC - 1) @(negedge clk);
    chk("b2b_busy_last", {31'b0, busy}, 32'd1);
    start = 1'b1; mdctr = 3'd2; A = 32'h8000_0001; B = 32'd3;
    @(negedge clk);
    start = 1'b0; mdctr = 3'd0;
    model(3'd1, 32'd7, 32'd9);
    chk("b2b_first_lo", LO, 32'd63);
    chk("b2b_first_hi", HI, hi_m);
    wait_idle("b2b_second", MC);
    model(3'd2, 32'h8000_0001, 32'd3);
    chk("b2b_second_hi", HI, hi_m);
    chk("b2b_second_lo", LO, lo_m);

    // Random ops against the model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
